dt_host_seq: RTL and testbench

- Host-side sequencer placed directly upstream of the Dyna_Tree root.
- Accepts host commands (LOAD, APPLY, READ, CLEAR) and a 4-bit token stream.
- Drives the root's TPort input (msg/tgt) and the tree-wide glob_com.
- Collects tokens the root returns during READ into an output FIFO with valid/ready handshake.

---
 rtl/dt_host_seq_if.sv | 34 +++
 rtl/dt_host_seq.sv | 167 ++++++++++++++++
 tb/tb_dt_host_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dt_host_seq_if.sv
// Host/tree-facing signal bundle for the Dyna_Tree host sequencer.
// slave = sequencer side, master = host plus root side.
interface dt_host_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       tok_in_valid;
  logic       tok_in_ready;
  logic [3:0] tok_in;
  logic       tok_out_valid;
  logic       tok_out_ready;
  logic [3:0] tok_out;
  logic       tok_out_last;
  logic [1:0] glob_com;
  logic [3:0] tree_in_msg;
  logic [1:0] tree_in_tgt;
  logic [3:0] tree_out_msg;
  logic [1:0] tree_out_tgt;
  logic       busy;
  logic       err_timeout;
  logic       err_overflow;

  modport slave (
    input  cmd_valid, cmd_op, tok_in_valid, tok_in, tok_out_ready, tree_out_msg, tree_out_tgt,
    output cmd_ready, tok_in_ready, tok_out_valid, tok_out, tok_out_last, glob_com,
           tree_in_msg, tree_in_tgt, busy, err_timeout, err_overflow
  );

  modport master (
    output cmd_valid, cmd_op, tok_in_valid, tok_in, tok_out_ready, tree_out_msg, tree_out_tgt,
    input  cmd_ready, tok_in_ready, tok_out_valid, tok_out, tok_out_last, glob_com,
           tree_in_msg, tree_in_tgt, busy, err_timeout, err_overflow
  );
endinterface

// File: rtl/dt_host_seq.sv
// Host sequencer in front of the Dyna_Tree root: LOAD/APPLY/READ/CLEAR plus read-back FIFO.
// Optional DT_HOST_SEQ_AUTO_READ_EN: APPLY chains straight into READ once the root is ready.
module dt_host_seq #(
  parameter int FIFO_DEPTH = 16,
  parameter int TREE_LEVEL = 4,
  parameter int TIMEOUT    = 255,
  parameter int RST_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  dt_host_seq_if.slave bus
);
  localparam logic [3:0] VK_EMPTY  = 4'd0;
  localparam logic [3:0] VMS_READY = 4'd1;
  localparam logic [3:0] VMS_BOMB  = 4'd3;
  localparam logic [3:0] VMS_READ  = 4'd4;
  localparam logic [3:0] VMS_APPLY = 4'd5;
  localparam logic [3:0] VK_EOF    = 4'd7;
  localparam logic [1:0] TO_PARENT   = 2'd0;
  localparam logic [1:0] TO_CHILDREN = 2'd1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOAD, S_LWAIT, S_APPLY, S_AWAIT,
    S_READ, S_RCOLLECT, S_RDONE, S_CLEAR, S_CWAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          root_ready, push, pop, full, wr_en, timed_out;

  assign root_ready = (bus.tree_out_tgt == TO_PARENT) && (bus.tree_out_msg == VMS_READY);
  assign push       = (state == S_RCOLLECT) && (bus.tree_out_tgt == TO_PARENT) &&
                      (bus.tree_out_msg > VMS_READY);
  assign pop        = bus.tok_out_ready && (count != '0);
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en      = push && (!full || pop);
  assign timed_out  = (cnt == CW'(TIMEOUT - 1));

  assign bus.tok_out_valid = (count != '0);
  assign bus.tok_out       = mem[rd_ptr];
  assign bus.tok_out_last  = (mem[rd_ptr] == VK_EOF);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.tree_out_msg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_INIT;
      cnt              <= '0;
      bus.cmd_ready    <= 1'b0;
      bus.tok_in_ready <= 1'b0;
      bus.glob_com     <= 2'b01;
      bus.tree_in_msg  <= VK_EMPTY;
      bus.tree_in_tgt  <= TO_CHILDREN;
      bus.busy         <= 1'b1;
      bus.err_timeout  <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      bus.tree_in_msg <= VK_EMPTY;
      bus.tree_in_tgt <= TO_CHILDREN;
      cnt             <= cnt + 1'b1;
      if (push && full && !pop) bus.err_overflow <= 1'b1;

      case (state)
        S_INIT: if (cnt == CW'(RST_CYCLES - 1)) begin
          state         <= S_IDLE;
          bus.glob_com  <= 2'b00;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        S_IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
          bus.cmd_ready    <= 1'b0;
          bus.busy         <= 1'b1;
          bus.err_timeout  <= 1'b0;
          bus.err_overflow <= 1'b0;
          cnt              <= '0;
          case (bus.cmd_op)
            2'd0: begin state <= S_LOAD;  bus.tok_in_ready <= 1'b1; end
            2'd1: begin state <= S_APPLY; bus.tree_in_msg <= VMS_APPLY; end
            2'd2: begin state <= S_READ;  bus.tree_in_msg <= VMS_READ; end
            default: begin state <= S_CLEAR; bus.tree_in_msg <= VMS_BOMB; end
          endcase
        end
        S_LOAD: if (bus.tok_in_valid) begin
          if (bus.tok_in == VK_EOF) begin
            state            <= S_LWAIT;
            bus.tok_in_ready <= 1'b0;
            cnt              <= '0;
          end else begin
            bus.tree_in_msg <= bus.tok_in;
          end
        end
        S_APPLY: begin state <= S_AWAIT;    cnt <= '0; end
        S_READ:  begin state <= S_RCOLLECT; cnt <= '0; end
        S_CLEAR: begin state <= S_CWAIT;    cnt <= '0; end
        S_CWAIT: if (cnt == CW'(2 * TREE_LEVEL + 1)) begin
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        // The first two AWAIT cycles may still carry a stale READY from before APPLY.
        S_AWAIT: if (cnt >= CW'(2) && root_ready) begin
`ifdef DT_HOST_SEQ_AUTO_READ_EN
          state           <= S_READ;
          bus.tree_in_msg <= VMS_READ;
`else
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
`endif
        end else if (timed_out) begin
          state           <= S_INIT;
          cnt             <= '0;
          bus.glob_com    <= 2'b01;
          bus.err_timeout <= 1'b1;
        end
        S_RCOLLECT: if (push && bus.tree_out_msg == VK_EOF) begin
          state <= S_RDONE;
          cnt   <= '0;
        end else if (timed_out) begin
          state           <= S_INIT;
          cnt             <= '0;
          bus.glob_com    <= 2'b01;
          bus.err_timeout <= 1'b1;
        end
        S_LWAIT, S_RDONE: if (root_ready) begin
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end else if (timed_out) begin
          state           <= S_INIT;
          cnt             <= '0;
          bus.glob_com    <= 2'b01;
          bus.err_timeout <= 1'b1;
        end
        default: begin
          state        <= S_INIT;
          cnt          <= '0;
          bus.glob_com <= 2'b01;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dt_host_seq.sv
// Randomized bench for dt_host_seq; the bench plays both host and tree root.
module tb_dt_host_seq;
  localparam int DEPTH = 4;
  localparam int TL    = 4;
  localparam int TMO   = 255;
  localparam int RC    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dt_host_seq_if bus ();

  dt_host_seq #(.FIFO_DEPTH(DEPTH), .TREE_LEVEL(TL), .TIMEOUT(TMO), .RST_CYCLES(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  bit          live   = 0;
  logic [4:0]  got[$];
  logic [3:0]  rd_data[$];

  function automatic logic [3:0] rand_tok();
    logic [3:0] v;
    do v = 4'($urandom_range(2, 15)); while (v == 4'd7);
    return v;
  endfunction

  // One clock step; every pop the DUT takes on the coming edge is recorded.
  task automatic tick();
    if (bus.tok_out_valid && bus.tok_out_ready) got.push_back({bus.tok_out_last, bus.tok_out});
    @(negedge clk);
    bus.tok_out_ready = live ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic root_idle();
    bus.tree_out_msg = 4'd0;
    bus.tree_out_tgt = 2'd1;
  endtask

  task automatic issue_cmd(input logic [1:0] op);
    int n = 0;
    while (!bus.cmd_ready && n < 400) begin tick(); n++; end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_wait got %0d want 1", bus.cmd_ready); end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.tok_in_ready !== 1'b0 || bus.tok_out_valid !== 1'b0 ||
        bus.tree_in_msg !== 4'd0 || bus.tree_in_tgt !== 2'd1 || bus.err_timeout !== 1'b0 ||
        bus.err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0d tir=%0d tov=%0d msg=%0d tgt=%0d et=%0d eo=%0d want 0 0 0 0 1 0 0",
               bus.cmd_ready, bus.tok_in_ready, bus.tok_out_valid, bus.tree_in_msg, bus.tree_in_tgt,
               bus.err_timeout, bus.err_overflow);
    end
    rst = 1'b0;
    for (int k = 0; k < RC; k++) begin
      checks++;
      if (bus.glob_com !== 2'b01 || bus.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL reset_glob cycle %0d got glob=%0d rdy=%0d want 1 0", k, bus.glob_com, bus.cmd_ready);
      end
      tick();
    end
    checks++;
    if (bus.glob_com !== 2'b00 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got glob=%0d rdy=%0d busy=%0d want 0 1 0", bus.glob_com, bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_load(input bit fixed, input int n);
    logic [3:0] toks[$];
    logic [3:0] want;
    int idx = 0;
    int cyc = 0;
    bit sent;
    if (fixed) begin toks.push_back(4'd8); toks.push_back(4'd12); end
    else for (int i = 0; i < n; i++) toks.push_back(rand_tok());
    toks.push_back(4'd7);
    issue_cmd(2'd0);
    while (idx < toks.size() && cyc < 200) begin
      checks++;
      if (bus.tok_in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %0d want 1", bus.tok_in_ready); end
      sent = fixed ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.tok_in_valid = sent;
      bus.tok_in       = sent ? toks[idx] : 4'($urandom);
      tick();
      cyc++;
      bus.tok_in_valid = 1'b0;
      want = (sent && toks[idx] != 4'd7) ? toks[idx] : 4'd0;
      checks++;
      if (bus.tree_in_msg !== want || bus.tree_in_tgt !== 2'd1) begin
        errors++; $display("FAIL load_fwd got msg=%0d tgt=%0d want msg=%0d tgt=1", bus.tree_in_msg, bus.tree_in_tgt, want);
      end
      if (sent) idx++;
    end
    checks++;
    if (idx != toks.size() || bus.tok_in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL load_end got sent=%0d tir=%0d busy=%0d want %0d 0 1", idx, bus.tok_in_ready, bus.busy, toks.size());
    end
    repeat ($urandom_range(0, 5)) tick();
    bus.tree_out_msg = 4'd1; bus.tree_out_tgt = 2'd0;
    tick();
    root_idle();
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_done got busy=%0d rdy=%0d want 0 1", bus.busy, bus.cmd_ready);
    end
  endtask

  // Read of rd_data followed by EOF; the expected FIFO image is the stream truncated to DEPTH.
  task automatic test_read(input bit live_mode, input bit send_ready);
    logic [3:0] stream[$];
    logic [4:0] exp[$];
    bit ovf_exp;
    int n;
    stream = rd_data;
    stream.push_back(4'd7);
    foreach (stream[i]) if (live_mode || exp.size() < DEPTH) exp.push_back({stream[i] == 4'd7, stream[i]});
    ovf_exp = !live_mode && (stream.size() > DEPTH);
    got.delete();
    live = live_mode;
    issue_cmd(2'd2);
    checks++;
    if (bus.tree_in_msg !== 4'd4 || bus.tree_in_tgt !== 2'd1) begin
      errors++; $display("FAIL read_drive got msg=%0d tgt=%0d want 4 1", bus.tree_in_msg, bus.tree_in_tgt);
    end
    tick();
    checks++;
    if (bus.tree_in_msg !== 4'd0) begin errors++; $display("FAIL read_drive_len got %0d want 0", bus.tree_in_msg); end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd3;
    foreach (stream[i]) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) != 0) begin
          bus.tree_out_msg = 4'($urandom); bus.tree_out_tgt = 2'($urandom_range(1, 3));
        end else begin
          bus.tree_out_msg = 4'($urandom_range(0, 1)); bus.tree_out_tgt = 2'd0;
        end
        tick();
      end
      bus.tree_out_msg = stream[i]; bus.tree_out_tgt = 2'd0;
      tick();
    end
    root_idle();
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL read_cmd_ignored got rdy=%0d busy=%0d want 0 1", bus.cmd_ready, bus.busy);
    end
    bus.cmd_valid = 1'b0;
    if (send_ready) begin
      repeat ($urandom_range(0, 3)) tick();
      bus.tree_out_msg = 4'd1; bus.tree_out_tgt = 2'd0;
      tick();
      root_idle();
      checks++;
      if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL read_done got busy=%0d rdy=%0d want 0 1", bus.busy, bus.cmd_ready);
      end
    end else begin
      n = 0;
      while (bus.err_timeout !== 1'b1 && n < 300) begin tick(); n++; end
      checks++;
      if (bus.err_timeout !== 1'b1 || bus.glob_com !== 2'b01) begin
        errors++; $display("FAIL read_timeout got et=%0d glob=%0d want 1 1", bus.err_timeout, bus.glob_com);
      end
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL read_timeout_idle got %0d want 1", bus.cmd_ready); end
    end
    checks++;
    if (bus.err_overflow !== ovf_exp) begin
      errors++; $display("FAIL read_overflow got %0d want %0d", bus.err_overflow, ovf_exp);
    end
    if (!live_mode) begin
      repeat (2) begin
        checks++;
        if (bus.tok_out_valid !== 1'b1 || bus.tok_out !== exp[0][3:0] || got.size() != 0) begin
          errors++; $display("FAIL read_hold got v=%0d tok=%0d pops=%0d want 1 %0d 0", bus.tok_out_valid, bus.tok_out, got.size(), exp[0][3:0]);
        end
        tick();
      end
    end
    live = 1'b1;
    n = 0;
    while (got.size() < exp.size() && n < 100) begin tick(); n++; end
    live = 1'b0;
    repeat (2) tick();
    checks++;
    if (got.size() != exp.size() || bus.tok_out_valid !== 1'b0) begin
      errors++; $display("FAIL read_count got %0d valid=%0d want %0d 0", got.size(), bus.tok_out_valid, exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL read_data[%0d] got last=%0d tok=%0d want last=%0d tok=%0d", i, got[i][4], got[i][3:0], exp[i][4], exp[i][3:0]);
      end
    end
  endtask

  task automatic test_apply();
    issue_cmd(2'd1);
    checks++;
    if (bus.tree_in_msg !== 4'd5 || bus.tree_in_tgt !== 2'd1) begin
      errors++; $display("FAIL apply_drive got msg=%0d tgt=%0d want 5 1", bus.tree_in_msg, bus.tree_in_tgt);
    end
    // A READY inside the APPLY cycle and the two blind cycles must not end the wait.
    bus.tree_out_msg = 4'd1; bus.tree_out_tgt = 2'd0;
    tick();
    checks++;
    if (bus.tree_in_msg !== 4'd0) begin errors++; $display("FAIL apply_len got %0d want 0", bus.tree_in_msg); end
    repeat (2) tick();
    root_idle();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL apply_blind got busy=%0d want 1", bus.busy); end
    repeat ($urandom_range(1, 6)) tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL apply_wait got busy=%0d want 1", bus.busy); end
    bus.tree_out_msg = 4'd1; bus.tree_out_tgt = 2'd0;
    tick();
    root_idle();
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL apply_done got busy=%0d rdy=%0d want 0 1", bus.busy, bus.cmd_ready);
    end
  endtask

  task automatic test_timeout();
    issue_cmd(2'd1);
    checks++;
    if (bus.err_overflow !== 1'b0 || bus.err_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got eo=%0d et=%0d want 0 0", bus.err_overflow, bus.err_timeout);
    end
    repeat (TMO) tick();
    checks++;
    if (bus.err_timeout !== 1'b0 || bus.glob_com !== 2'b00) begin
      errors++; $display("FAIL timeout_early got et=%0d glob=%0d want 0 0", bus.err_timeout, bus.glob_com);
    end
    tick();
    for (int k = 0; k < RC; k++) begin
      checks++;
      if (bus.err_timeout !== 1'b1 || bus.glob_com !== 2'b01 || bus.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL timeout_init cycle %0d got et=%0d glob=%0d rdy=%0d want 1 1 0", k, bus.err_timeout, bus.glob_com, bus.cmd_ready);
      end
      tick();
    end
    checks++;
    if (bus.glob_com !== 2'b00 || bus.cmd_ready !== 1'b1 || bus.err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_idle got glob=%0d rdy=%0d et=%0d want 0 1 1", bus.glob_com, bus.cmd_ready, bus.err_timeout);
    end
  endtask

  task automatic test_clear();
    issue_cmd(2'd3);
    checks++;
    if (bus.tree_in_msg !== 4'd3 || bus.tree_in_tgt !== 2'd1 || bus.err_timeout !== 1'b0) begin
      errors++; $display("FAIL clear_drive got msg=%0d tgt=%0d et=%0d want 3 1 0", bus.tree_in_msg, bus.tree_in_tgt, bus.err_timeout);
    end
    for (int k = 1; k <= 2 * TL + 3; k++) begin
      tick();
      checks++;
      if (bus.cmd_ready !== (k == 2 * TL + 3) || bus.tree_in_msg !== 4'd0) begin
        errors++; $display("FAIL clear_wait cycle %0d got rdy=%0d msg=%0d want %0d 0", k, bus.cmd_ready, bus.tree_in_msg, (k == 2 * TL + 3));
      end
    end
  endtask

  task automatic test_midreset();
    issue_cmd(2'd2);
    tick();
    bus.tree_out_msg = 4'd9; bus.tree_out_tgt = 2'd0;
    tick();
    root_idle();
    checks++;
    if (bus.tok_out_valid !== 1'b1) begin errors++; $display("FAIL midreset_fill got %0d want 1", bus.tok_out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.tok_out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.tree_in_msg !== 4'd0 || bus.tree_in_tgt !== 2'd1) begin
      errors++; $display("FAIL midreset_state got tov=%0d busy=%0d msg=%0d tgt=%0d want 0 1 0 1", bus.tok_out_valid, bus.busy, bus.tree_in_msg, bus.tree_in_tgt);
    end
    for (int k = 0; k < RC; k++) begin
      checks++;
      if (bus.glob_com !== 2'b01) begin errors++; $display("FAIL midreset_glob cycle %0d got %0d want 1", k, bus.glob_com); end
      tick();
    end
    checks++;
    if (bus.glob_com !== 2'b00 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_idle got glob=%0d rdy=%0d want 0 1", bus.glob_com, bus.cmd_ready);
    end
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = 2'd0;
    bus.tok_in_valid  = 1'b0;
    bus.tok_in        = 4'd0;
    bus.tok_out_ready = 1'b0;
    root_idle();

    test_reset();
    test_load(1'b1, 0);
    repeat (2) test_load(1'b0, int'($urandom_range(1, 6)));

    rd_data.delete(); rd_data.push_back(4'd8); rd_data.push_back(4'd9);
    test_read(1'b0, 1'b1);
    repeat (3) begin
      rd_data.delete();
      repeat ($urandom_range(0, DEPTH - 1)) rd_data.push_back(rand_tok());
      test_read(1'b1, 1'b1);
    end

    test_apply();

    rd_data.delete();
    repeat (5) rd_data.push_back(rand_tok());
    test_read(1'b0, 1'b1);

    test_timeout();
    test_clear();

    rd_data.delete();
    repeat (2) rd_data.push_back(rand_tok());
    test_read(1'b0, 1'b0);

    test_midreset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
